// File: rtl/mac_job_sequencer_pkg.sv
// Shared constants, mode encodings and sequencer state encodings for the MAC job path.
package mac_const;

  localparam int unsigned MAC_MIN_WIDTH   = 8;
  localparam int unsigned MAC_ACC_WIDTH   = 32;
  localparam int unsigned MAC_CONF_WIDTH  = 3;
  localparam int unsigned MAC_LEN_WIDTH   = 8;
  localparam int unsigned MAC_PIPE_LAT    = 1;
  localparam int unsigned MAC_ACC_SEL_BIT = MAC_CONF_WIDTH - 1;

  typedef enum logic [1:0] {
    MAC_SINGLE  = 2'd0,
    MAC_DUAL    = 2'd1,
    MAC_QUAD    = 2'd2,
    MAC_ILLEGAL = 2'd3
  } mac_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/mac_job_sequencer_counter.sv
// Loadable down-counter with zero flag; shared between beat counting and drain timing.
module mac_seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mac_job_sequencer.sv
// Job-level sequencer for one MAC block: config load, accumulator clear, operand gating,
// pipeline drain and a single valid/ready result per job.
module mac_job_sequencer
  import mac_const::*;
#(
  parameter int unsigned MIN_W   = MAC_MIN_WIDTH,
  parameter int unsigned ACC_W   = MAC_ACC_WIDTH,
  parameter int unsigned CONF_W  = MAC_CONF_WIDTH,
  parameter int unsigned LEN_W   = MAC_LEN_WIDTH,
  parameter int unsigned MAC_LAT = MAC_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [1:0]              job_mode,
  input  logic                    job_acc,
  input  logic [ACC_W-1:0]        job_init,
  input  logic [LEN_W-1:0]        job_len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [4*MIN_W-1:0]      op_a,
  input  logic [MIN_W-1:0]        op_b,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [ACC_W+CONF_W-1:0] mac_cfg,
  output logic [4*MIN_W-1:0]      mac_a,
  output logic [MIN_W-1:0]        mac_b,
  input  logic [ACC_W-1:0]        mac_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data,
  output logic                    res_err,
  output logic                    busy
);

  seq_state_t                r_state;
  logic                      r_job_ready;
  logic                      r_op_ready;
  logic                      r_mac_en;
  logic                      r_mac_clr;
  logic [ACC_W+CONF_W-1:0]   r_mac_cfg;
  logic [4*MIN_W-1:0]        r_mac_a;
  logic [MIN_W-1:0]          r_mac_b;
  logic                      r_res_valid;
  logic [ACC_W-1:0]          r_res_data;
  logic                      r_res_err;
  logic [LEN_W-1:0]          r_len;

  logic [CONF_W-1:0]         w_conf;
  logic [LEN_W-1:0]          w_eff_len;
  logic [LEN_W-1:0]          w_drain_len;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_load;
  logic [LEN_W-1:0]          w_load_val;
  logic                      w_dec;
  logic [LEN_W-1:0]          w_cnt;
  logic                      w_zero;

  always_comb begin
    w_conf         = '0;
    w_conf[1:0]    = job_mode;
    w_conf[CONF_W-1] = job_acc;
  end

  assign w_eff_len   = r_mac_cfg[CONF_W-1] ? r_len : LEN_W'(1);
  assign w_drain_len = LEN_W'(MAC_LAT + 1);
  assign w_accept    = op_valid & r_op_ready;
  assign w_last      = (w_cnt == LEN_W'(1));

  // One counter serves both phases: beats remaining in RUN, drain wait in DRAIN.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_load     = 1'b1;
        w_load_val = (w_eff_len == '0) ? w_drain_len : w_eff_len;
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_last) begin
            w_load     = 1'b1;
            w_load_val = w_drain_len;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_DRAIN: w_dec = ~w_zero;
      default: ;
    endcase
  end

  mac_seq_counter #(
    .W (LEN_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_job_ready <= 1'b1;
      r_op_ready  <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_cfg   <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_len       <= '0;
    end else begin
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_mac_cfg   <= {job_init, w_conf};
            r_len       <= job_len;
            r_job_ready <= 1'b0;
            r_res_data  <= '0;
            if (job_mode == MAC_ILLEGAL) begin
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_res_err <= 1'b0;
              r_mac_clr <= 1'b1;
              r_state   <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (w_eff_len == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_op_ready <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_mac_a  <= op_a;
            r_mac_b  <= op_b;
            r_mac_en <= 1'b1;
            if (w_last) begin
              r_op_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_zero) begin
            r_res_data  <= mac_c;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_job_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign job_ready = r_job_ready;
  assign op_ready  = r_op_ready;
  assign mac_en    = r_mac_en;
  assign mac_clr   = r_mac_clr;
  assign mac_cfg   = r_mac_cfg;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign busy      = (r_state != S_IDLE);

endmodule
